// File: rtl/ripple_count_extender_pkg.sv
// Shared constants and FSM encoding for the ripple counter extender.
// Defaults here are the reference build of the block.
package ripple_count_extender_pkg;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_EXT_W       = 8;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/ripple_count_extender_sync.sv
// Per-bit synchronizer followed by a two-sample stability filter.
// stable_o only rises once the whole chain holds post-reset samples.
module count_sync_filter #(
  parameter int unsigned W      = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] val_o,
  output logic         stable_o
);

  logic [STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0]             prev_q;
  logic [STAGES:0]          fill_q;

  // Shift chain, previous-sample register and pipeline fill tracker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      fill_q <= {fill_q[STAGES-1:0], 1'b1};
    end
  end

  assign val_o    = sync_q[STAGES-1];
  assign stable_o = fill_q[STAGES] && (val_o == prev_q);

endmodule

// File: rtl/ripple_count_extender.sv
// Extends a 4-bit asynchronous ripple counter with a wrap epoch
// counter, plus a held snapshot port and sticky error flags.
module ripple_count_extender
  import ripple_count_extender_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned EXT_W       = DEF_EXT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         q_in,
  input  logic               snap_req,
  input  logic               snap_ready,
  input  logic               clr_err,
  output logic [EXT_W+3:0]   count,
  output logic [EXT_W+3:0]   snap_data,
  output logic               snap_valid,
  output logic               wrap_pulse,
  output logic               err_skip,
  output logic               err_ovf,
  output logic               err_drop
);

  logic [CNT_W-1:0] s_val;
  logic             s_ok;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] q_stable_q, q_stable_d;
  logic [EXT_W-1:0] ext_q, ext_d;
  logic [EXT_W+3:0] snap_data_q;
  logic             snap_valid_q;
  logic             wrap_q, skip_q, ovf_q, drop_q;

  logic [CNT_W-1:0] delta;
  logic             upd, wrap_evt, skip_evt, ovf_evt;
  logic             seed, track, snap_load, snap_done, drop_evt;

  count_sync_filter #(
    .W      (CNT_W),
    .STAGES (SYNC_STAGES)
  ) u_filt (
    .clk      (clk),
    .rst_n    (reset),
    .d_i      (q_in),
    .val_o    (s_val),
    .stable_o (s_ok)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:  if (s_ok) state_d = S_RUN;
      S_RUN:   if (snap_req) state_d = S_HOLD;
      S_HOLD:  if (snap_valid_q && snap_ready) state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // FSM output decode: seeding, tracking and snapshot control strobes
  always_comb begin
    seed      = 1'b0;
    track     = 1'b0;
    snap_load = 1'b0;
    snap_done = 1'b0;
    drop_evt  = 1'b0;
    unique case (1'b1)
      (state_q == S_RUN): begin
        track     = 1'b1;
        snap_load = snap_req;
      end
      (state_q == S_HOLD): begin
        track     = 1'b1;
        snap_done = snap_valid_q && snap_ready;
        drop_evt  = snap_req;
      end
      default: seed = s_ok;
    endcase
  end

  // Classify an accepted change: increment, wrap, skip, epoch overflow
  always_comb begin
    delta      = s_val - q_stable_q;
    upd        = track && s_ok && (s_val != q_stable_q);
    wrap_evt   = upd && (s_val < q_stable_q);
    skip_evt   = upd && (delta >= 4'd2);
    ovf_evt    = wrap_evt && (ext_q == '1);
    q_stable_d = q_stable_q;
    ext_d      = ext_q;
    if (seed) begin
      q_stable_d = s_val;
      ext_d      = '0;
    end else if (upd) begin
      q_stable_d = s_val;
      if (wrap_evt) ext_d = ext_q + 1'b1;
    end
  end

  // Count, snapshot and sticky flag registers; a set beats clr_err
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_stable_q   <= '0;
      ext_q        <= '0;
      snap_data_q  <= '0;
      snap_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
      skip_q       <= 1'b0;
      ovf_q        <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      q_stable_q <= q_stable_d;
      ext_q      <= ext_d;
      wrap_q     <= wrap_evt;
      if (snap_load) begin
        snap_data_q  <= count;
        snap_valid_q <= 1'b1;
      end else if (snap_done) begin
        snap_valid_q <= 1'b0;
      end
      skip_q <= skip_evt || (skip_q && !clr_err);
      ovf_q  <= ovf_evt  || (ovf_q  && !clr_err);
      drop_q <= drop_evt || (drop_q && !clr_err);
    end
  end

  assign count      = {ext_q, q_stable_q};
  assign snap_data  = snap_data_q;
  assign snap_valid = snap_valid_q;
  assign wrap_pulse = wrap_q;
  assign err_skip   = skip_q;
  assign err_ovf    = ovf_q;
  assign err_drop   = drop_q;

endmodule
